irq_source_unit: RTL and testbench
==================================

# irq_source_unit

Machine-level interrupt source block for the 5-stage RISC-V core. It holds a 64-bit `mtime` counter and `mtimecmp` compare register, a software-interrupt bit, and a synchronised, edge-latched external interrupt line. It exposes them as memory-mapped registers on the core's data-memory side. It sits directly upstream of the exception unit and drives that unit's `interrupt` input plus a matching cause code.

## Interface
Parameters:
- `PRESCALE`, 1: core cycles per `mtime` increment; legal range 1..65535.
- `ADDR_W`, 5: byte-address width of the register window.

Ports:
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: bus request, single-cycle pulse or held.
- `we` in 1: write enable; 1 = write, 0 = read.
- `addr` in `ADDR_W`: byte address; bits [1:0] are ignored.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ack`=1.
- `ack` out 1: one-cycle completion pulse.
- `ext_irq_in` in 1: asynchronous external interrupt line.
- `interrupt` out 1: level interrupt to the exception unit.
- `irq_cause` out 32: mcause value for the current highest-priority interrupt.

## Operation
Register map, word-aligned:
- 0x00 `msip`: bit0 is the software pending bit. Other bits read 0.
- 0x08 / 0x0C: `mtimecmp` low / high word.
- 0x10 / 0x14: `mtime` low / high word.
- 0x18 `meip`: bit0 is external pending. Write-1-to-clear.
- 0x1C `men`: enable bits. bit0 = MEIE, bit1 = MSIE, bit2 = MTIE.
- Unmapped addresses: reads return 0, writes are dropped, `ack` still pulses.

Counter:
- Internal prescale counter wraps at `PRESCALE`-1. `mtime` increments by 1 on the wrap.
- `mtime` is 64-bit and wraps modulo 2^64, from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to either `mtime` word overrides that cycle's increment and resets the prescale counter.

Pending sources:
- Timer pending (`mtip`) = unsigned `mtime >= mtimecmp`. It is level-sensitive and clears only when `mtimecmp` or `mtime` is rewritten.
- External: `ext_irq_in` passes through a 2-flop synchroniser, then a rising-edge detect sets `meip`.
- If a `meip` set and a W1C clear land in the same cycle, set wins.

Output and priority:
- `interrupt` = OR of (`meip`&MEIE, `msip`&MSIE, `mtip`&MTIE), registered.
- Priority is external > software > timer.
- `irq_cause` values: 0x8000000B external, 0x80000003 software, 0x80000007 timer. It holds 0 when `interrupt`=0.

Reset values:
- `rdata`=0, `ack`=0, `interrupt`=0, `irq_cause`=0.
- `mtime`=0, `mtimecmp`=all ones, `msip`=0, `meip`=0, `men`=0, synchroniser flops=0.

Reset is asynchronous: assertion mid-transaction aborts the access, `ack` is not issued, and all state returns to reset values immediately.

## Timing
Bus protocol:
- `req` is sampled at edge N while `ack`=0. A write takes effect at edge N.
- `ack`=1 and `rdata` are valid during cycle N+1. Read data is the register value before edge N.
- A `req` present while `ack`=1 is ignored, so the maximum rate is one access per two cycles. The master holds `req` until it sees `ack`.

Interrupt latency:
- `ext_irq_in` rise to `interrupt`=1: 4 cycles (sync1, sync2, `meip` set, output register).
- `mtime` reaching `mtimecmp` (or a register write that satisfies the compare) to `interrupt`=1: 1 cycle.
- A register write that removes the last enabled pending source drops `interrupt` 1 cycle after the write edge.

Counter timing:
- With `PRESCALE`=1, `mtime` increments every cycle, starting at the first edge after reset release.
- 64-bit writes are non-atomic. Software writes `mtimecmp` high=all ones first, then low, then high.

## Structure
- Shared package `irq_pkg` holds:
  - register offset constants (`IRQ_MSIP`, `IRQ_MTIMECMP_LO/HI`, `IRQ_MTIME_LO/HI`, `IRQ_MEIP`, `IRQ_MEN`);
  - cause constants `CAUSE_MEI`, `CAUSE_MSI`, `CAUSE_MTI`;
  - enable bit indices.
- Sub-module `irq_sync_edge` contains the 2-flop synchroniser and rising-edge detector. It is reused for future external lines.
- Everything else lives in `irq_source_unit`: prescaler, `mtime`, bus decode, pending logic, priority encoder.

## Test plan
- Reset, then read 0x0C → `ack` 1 cycle later, `rdata`=0xFFFFFFFF. `interrupt`=0 throughout.
- `PRESCALE`=4: run 40 cycles, read 0x10 → 10 (±1 for the read-sample point). Write 0x10=0xFFFFFFFF and 0x14=0xFFFFFFFF, wait 4 cycles → `mtime`=0.
- `men`=0x4, `mtimecmp`={0,20}, `mtime`=0 → `interrupt` rises 1 cycle after `mtime`=20, `irq_cause`=0x80000007. Write 0x0C=0xFFFFFFFF → `interrupt` drops 1 cycle later.
- `men`=0x1, pulse `ext_irq_in` for 1 cycle → `interrupt`=1 after 4 cycles, `irq_cause`=0x8000000B. Write 0x18=1 → clears. A new edge arriving in the same cycle as the clear leaves `meip`=1.
- All three sources pending with `men`=0x7 → cause 0x8000000B. Clear `meip` → 0x80000003. Write `msip`=0 → 0x80000007.
- Assert `rst` low in the cycle a write is accepted → no `ack`. All outputs are 0 immediately; `mtimecmp` reads all ones after release.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Package  : irq_pkg
// Purpose  : Shared register offsets, mcause codes and enable-bit indices for
//            the machine-level interrupt source block.
// Revision : 1.0 - initial release
// ============================================================================

package irq_pkg;

    // Word-aligned byte offsets inside the register window
    localparam logic [31:0] IRQ_MSIP        = 32'h0000_0000;
    localparam logic [31:0] IRQ_MTIMECMP_LO = 32'h0000_0008;
    localparam logic [31:0] IRQ_MTIMECMP_HI = 32'h0000_000C;
    localparam logic [31:0] IRQ_MTIME_LO    = 32'h0000_0010;
    localparam logic [31:0] IRQ_MTIME_HI    = 32'h0000_0014;
    localparam logic [31:0] IRQ_MEIP        = 32'h0000_0018;
    localparam logic [31:0] IRQ_MEN         = 32'h0000_001C;

    // mcause values (interrupt bit set, exception code in the low bits)
    localparam logic [31:0] CAUSE_MEI  = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MSI  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_NONE = 32'h0000_0000;

    // Bit positions inside the men register
    localparam int EN_MEIE = 0;
    localparam int EN_MSIE = 1;
    localparam int EN_MTIE = 2;
    localparam int EN_W    = 3;

    // Fixed priority: external > software > timer; zero when nothing is enabled+pending
    function automatic logic [31:0] irq_cause_of(input logic [EN_W-1:0] pend_en);
        logic [31:0] cause;
        cause = CAUSE_NONE;
        if (pend_en[EN_MEIE]) begin
            cause = CAUSE_MEI;
        end else if (pend_en[EN_MSIE]) begin
            cause = CAUSE_MSI;
        end else if (pend_en[EN_MTIE]) begin
            cause = CAUSE_MTI;
        end
        return cause;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Purpose  : Two-flop synchroniser for an asynchronous interrupt line followed
//            by a rising-edge detector producing a one-cycle pulse.
// Revision : 1.0 - initial release
// ============================================================================

module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Metastability chain plus one delayed copy of the synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/irq_source_unit.sv
`default_nettype none
// ============================================================================
// Module   : irq_source_unit
// Purpose  : Machine-level interrupt sources (mtime/mtimecmp timer, software
//            pending bit, edge-latched external line) behind a small
//            memory-mapped register window; drives interrupt + mcause.
// Revision : 1.0 - initial release
// ============================================================================

module irq_source_unit
    import irq_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    input  logic              ext_irq_in,
    output logic              interrupt,
    output logic [31:0]       irq_cause
);

    localparam logic [15:0] c_PS_LAST = 16'(PRESCALE - 1);

    logic [15:0]     ps_q,       ps_d;
    logic [63:0]     mtime_q,    mtime_d;
    logic [63:0]     mtimecmp_q, mtimecmp_d;
    logic            msip_q,     msip_d;
    logic            meip_q,     meip_d;
    logic [EN_W-1:0] men_q,      men_d;
    logic            ack_q,      ack_d;
    logic [31:0]     rdata_q,    rdata_d;
    logic            irq_q,      irq_d;
    logic [31:0]     cause_q,    cause_d;

    logic            w_accept;
    logic            w_wr;
    logic            w_mtip;
    logic            w_ext_rise;
    logic [EN_W-1:0] w_pend_en;
    logic [31:0]     w_off;

    irq_sync_edge u_ext_sync (
        .clk     (clk),
        .rst_n   (rst),
        .async_i (ext_irq_in),
        .rise_o  (w_ext_rise)
    );

    // A request is only taken while no ack is outstanding, so back-to-back
    // accesses are naturally spaced two cycles apart.
    assign w_accept = req & ~ack_q;
    assign w_wr     = w_accept & we;
    assign w_off    = 32'(addr) & ~32'h3;
    assign w_mtip   = (mtime_q >= mtimecmp_q);

    // Enabled-and-pending vector feeding the priority encoder
    always_comb begin
        w_pend_en          = '0;
        w_pend_en[EN_MEIE] = meip_q & men_q[EN_MEIE];
        w_pend_en[EN_MSIE] = msip_q & men_q[EN_MSIE];
        w_pend_en[EN_MTIE] = w_mtip & men_q[EN_MTIE];
    end

    // Next-state: prescaled timer, bus writes/reads, meip latch, output regs
    always_comb begin
        ps_d       = ps_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        meip_d     = meip_q;
        men_d      = men_q;
        rdata_d    = '0;
        ack_d      = w_accept;

        if (ps_q == c_PS_LAST) begin
            ps_d    = '0;
            mtime_d = mtime_q + 64'd1;
        end else begin
            ps_d = ps_q + 16'd1;
        end

        // Writes to mtime replace this cycle's increment and restart the prescaler
        if (w_wr) begin
            case (w_off)
                IRQ_MSIP:        msip_d = wdata[0];
                IRQ_MTIMECMP_LO: mtimecmp_d[31:0]  = wdata;
                IRQ_MTIMECMP_HI: mtimecmp_d[63:32] = wdata;
                IRQ_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], wdata};
                    ps_d    = '0;
                end
                IRQ_MTIME_HI: begin
                    mtime_d = {wdata, mtime_q[31:0]};
                    ps_d    = '0;
                end
                IRQ_MEIP: begin
                    if (wdata[0]) begin
                        meip_d = 1'b0;
                    end
                end
                IRQ_MEN:         men_d = wdata[EN_W-1:0];
                default: ;
            endcase
        end

        // A new edge beats a simultaneous write-1-to-clear
        if (w_ext_rise) begin
            meip_d = 1'b1;
        end

        if (w_accept) begin
            case (w_off)
                IRQ_MSIP:        rdata_d = {31'd0, msip_q};
                IRQ_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                IRQ_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                IRQ_MTIME_LO:    rdata_d = mtime_q[31:0];
                IRQ_MTIME_HI:    rdata_d = mtime_q[63:32];
                IRQ_MEIP:        rdata_d = {31'd0, meip_q};
                IRQ_MEN:         rdata_d = {{(32-EN_W){1'b0}}, men_q};
                default:         rdata_d = '0;
            endcase
        end

        irq_d   = |w_pend_en;
        cause_d = irq_cause_of(w_pend_en);
    end

    // State registers; reset clears everything except mtimecmp, which parks at all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q       <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            meip_q     <= 1'b0;
            men_q      <= '0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            cause_q    <= '0;
        end else begin
            ps_q       <= ps_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            meip_q     <= meip_d;
            men_q      <= men_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            cause_q    <= cause_d;
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign interrupt = irq_q;
    assign irq_cause = cause_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_source_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_source_unit
// Purpose  : Self-checking bench for irq_source_unit (PRESCALE=4) with an
//            arithmetic reference model and directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================

module tb_irq_source_unit;

    localparam int P  = 4;
    localparam int AW = 5;

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [31:0]   wdata = '0;
    logic          ext   = 1'b0;
    logic [31:0]   rdata;
    logic          ack;
    logic          interrupt;
    logic [31:0]   irq_cause;

    int checks = 0;
    int errors = 0;
    bit rnd_done = 1'b0;

    always #5 clk = ~clk;

    irq_source_unit #(.PRESCALE(P), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ack        (ack),
        .ext_irq_in (ext),
        .interrupt  (interrupt),
        .irq_cause  (irq_cause)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // mtime is derived from elapsed edges since the last (re)load, not a counter.
    longint unsigned m_n   = 0;
    longint unsigned m_n0  = 0;
    logic [63:0]     m_base = '0;
    logic [63:0]     m_cmp  = '1;
    logic            m_msip = 1'b0;
    logic            m_meip = 1'b0;
    logic [2:0]      m_men  = '0;
    logic            m_h1 = 1'b0, m_h2 = 1'b0, m_h3 = 1'b0;
    logic            e_ack = 1'b0;
    logic            e_int = 1'b0;
    logic [31:0]     e_rdata = '0;
    logic [31:0]     e_cause = '0;

    function automatic logic [63:0] model_mtime();
        return m_base + 64'((m_n - m_n0) / longint'(P));
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic [63:0] mt);
        logic [4:0] w;
        w = {a[4:2], 2'b00};
        case (w)
            5'h00:   return {31'd0, m_msip};
            5'h08:   return m_cmp[31:0];
            5'h0C:   return m_cmp[63:32];
            5'h10:   return mt[31:0];
            5'h14:   return mt[63:32];
            5'h18:   return {31'd0, m_meip};
            5'h1C:   return {29'd0, m_men};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n = 0; m_n0 = 0; m_base = '0; m_cmp = '1;
            m_msip = 1'b0; m_meip = 1'b0; m_men = '0;
            m_h1 = 1'b0; m_h2 = 1'b0; m_h3 = 1'b0;
            e_ack = 1'b0; e_int = 1'b0; e_rdata = '0; e_cause = '0;
        end else begin
            logic [63:0] mt;
            logic [31:0] c;
            logic        set, clr;
            logic [4:0]  w;
            mt = model_mtime();
            c  = 32'd0;
            if (m_meip && m_men[0])               c = 32'h8000000B;
            else if (m_msip && m_men[1])          c = 32'h80000003;
            else if ((mt >= m_cmp) && m_men[2])   c = 32'h80000007;
            e_int   = (c != 32'd0);
            e_cause = c;
            set  = m_h2 && !m_h3;
            m_h3 = m_h2; m_h2 = m_h1; m_h1 = ext;
            clr  = 1'b0;
            if (req && !e_ack) begin
                e_rdata = model_read(addr, mt);
                if (we) begin
                    w = {addr[4:2], 2'b00};
                    case (w)
                        5'h00: m_msip = wdata[0];
                        5'h08: m_cmp[31:0]  = wdata;
                        5'h0C: m_cmp[63:32] = wdata;
                        5'h10: begin m_base = {mt[63:32], wdata}; m_n0 = m_n + 1; end
                        5'h14: begin m_base = {wdata, mt[31:0]};  m_n0 = m_n + 1; end
                        5'h18: clr = wdata[0];
                        5'h1C: m_men = wdata[2:0];
                        default: ;
                    endcase
                end
                e_ack = 1'b1;
            end else begin
                e_ack = 1'b0;
            end
            if (set)      m_meip = 1'b1;
            else if (clr) m_meip = 1'b0;
            m_n++;
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        chk("ack", {31'd0, ack}, {31'd0, e_ack});
        if (e_ack) chk("rdata", rdata, e_rdata);
        chk("interrupt", {31'd0, interrupt}, {31'd0, e_int});
        chk("irq_cause", irq_cause, e_cause);
    end

    // ---------------- bus helpers ----------------
    task automatic bus_start(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = 1'b1; we = w; addr = a; wdata = d;
    endtask

    task automatic bus_wait(output logic [31:0] d);
        int k;
        bit got;
        k = 0; got = 1'b0; d = '0;
        while (!got && k < 8) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                d = rdata;
                got = 1'b1;
            end
            k++;
        end
        req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL bus_ack: no ack within 8 cycles, required ack=1");
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_start(1'b1, a, d);
        bus_wait(dummy);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, output logic [31:0] d);
        bus_start(1'b0, a, 32'd0);
        bus_wait(d);
    endtask

    task automatic pulse_ext();
        @(posedge clk); #1 ext = 1'b1;
        @(posedge clk); #1 ext = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_interrupt", {31'd0, interrupt}, 32'd0);
        chk("rst_cause", irq_cause, 32'd0);
        @(negedge clk) rst = 1'b1;

        bus_read(5'h0C, d);
        chk("mtimecmp_hi_reset", d, 32'hFFFFFFFF);
        chk("no_irq_after_reset", {31'd0, interrupt}, 32'd0);

        // Prescaled counting: 41 edges after reload -> 10
        bus_write(5'h10, 32'd0);
        repeat (40) @(posedge clk);
        bus_read(5'h10, d);
        checks++;
        if (d < 32'd9 || d > 32'd11) begin
            errors++;
            $display("FAIL mtime_prescale: got %0d, expected 9..11", d);
        end

        // 64-bit wrap
        bus_write(5'h10, 32'hFFFFFFFF);
        bus_write(5'h14, 32'hFFFFFFFF);
        repeat (4) @(posedge clk);
        bus_read(5'h10, d);
        chk("mtime_wrap_lo", d, 32'd0);
        bus_read(5'h14, d);
        chk("mtime_wrap_hi", d, 32'd0);

        // Timer interrupt: mtime hits 20 at 80 edges after reload, irq one edge later
        bus_write(5'h08, 32'd20);
        bus_write(5'h0C, 32'd0);
        bus_write(5'h1C, 32'h4);
        bus_write(5'h10, 32'd0);
        k = 0;
        while (interrupt !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("timer_latency", k, 32'd81);
        chk("timer_cause", irq_cause, 32'h80000007);
        bus_write(5'h0C, 32'hFFFFFFFF);
        chk("timer_hold_in_ack", {31'd0, interrupt}, 32'd1);
        @(negedge clk);
        chk("timer_drop", {31'd0, interrupt}, 32'd0);

        // External line: 4 edges from rise to interrupt
        bus_write(5'h1C, 32'h1);
        pulse_ext();
        k = 0;
        while (interrupt !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("ext_latency", k, 32'd4);
        chk("ext_cause", irq_cause, 32'h8000000B);
        bus_write(5'h18, 32'h1);
        @(negedge clk);
        chk("ext_clear", {31'd0, interrupt}, 32'd0);

        // Rising edge lands on the same edge as the W1C: set wins
        @(posedge clk); #1 ext = 1'b1;
        @(posedge clk);
        bus_start(1'b1, 5'h18, 32'h1);
        bus_wait(d);
        bus_read(5'h18, d);
        chk("meip_set_wins", d, 32'd1);
        ext = 1'b0;
        bus_write(5'h18, 32'h1);
        bus_read(5'h18, d);
        chk("meip_cleared", d, 32'd0);

        // Priority with all three sources pending
        bus_write(5'h1C, 32'h7);
        bus_write(5'h00, 32'h1);
        bus_write(5'h0C, 32'hFFFFFFFF);
        bus_write(5'h08, 32'd0);
        bus_write(5'h0C, 32'd0);
        pulse_ext();
        repeat (5) @(negedge clk);
        chk("prio_all", irq_cause, 32'h8000000B);
        bus_write(5'h18, 32'h1);
        @(negedge clk);
        chk("prio_sw", irq_cause, 32'h80000003);
        bus_write(5'h00, 32'h0);
        @(negedge clk);
        chk("prio_timer", irq_cause, 32'h80000007);

        // Asynchronous reset while a write is in flight
        bus_start(1'b1, 5'h08, 32'h12345678);
        @(negedge clk);
        #1;
        rst = 1'b0; req = 1'b0; we = 1'b0;
        #1;
        chk("arst_interrupt", {31'd0, interrupt}, 32'd0);
        chk("arst_cause", irq_cause, 32'd0);
        chk("arst_ack", {31'd0, ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus_read(5'h08, d);
        chk("arst_cmp_lo", d, 32'hFFFFFFFF);
        bus_read(5'h1C, d);
        chk("arst_men", d, 32'd0);

        // Randomised traffic against the model
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [AW-1:0] a;
                    logic [31:0]   v;
                    a = AW'({$urandom_range(0, 7), 2'($urandom_range(0, 3))});
                    case ({a[4:2], 2'b00})
                        5'h0C, 5'h14: v = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'd0;
                        5'h08, 5'h10: v = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF0
                                                                      : 32'($urandom_range(0, 300));
                        default:      v = $urandom;
                    endcase
                    bus_start(1'($urandom_range(0, 1)), a, v);
                    bus_wait(d);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    if ($urandom_range(0, 9) == 0) ext = ~ext;
                end
            end
        join

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
